decode_unit: RTL and testbench

DECODE_UNIT -- requirements
Module: decode_unit

---
 rtl/decode_unit.sv | 128 ++++++++++++
 tb/tb_decode_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// Decode stage: 16x16 register file with two bypassed writeback ports,
// opcode-class decode, and a stallable/flushable output register.
module decode_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        is_branch_taken,
  input  logic [15:0] instr,
  input  logic [19:0] rdvalmem1,
  input  logic [19:0] rdvalmem2,
  output logic [3:0]  opcode,
  output logic [15:0] op1,
  output logic [15:0] op2,
  output logic [4:0]  imm,
  output logic        imm_flag,
  output logic [15:0] branch_target,
  output logic [15:0] instrout
);

  logic [15:0][15:0] rf_q, rf_d;

  logic [3:0]  opcode_q, opcode_d;
  logic [15:0] op1_q, op1_d;
  logic [15:0] op2_q, op2_d;
  logic [4:0]  imm_q, imm_d;
  logic        imm_flag_q, imm_flag_d;
  logic [15:0] branch_target_q, branch_target_d;
  logic [15:0] instrout_q, instrout_d;

  // Port 2 is applied last so it wins when both ports hit the same index.
  always_comb begin
    rf_d = rf_q;
    if (rdvalmem1[19:16] != 4'd0) rf_d[rdvalmem1[19:16]] = rdvalmem1[15:0];
    if (rdvalmem2[19:16] != 4'd0) rf_d[rdvalmem2[19:16]] = rdvalmem2[15:0];
  end

  function automatic logic [15:0] rd_reg(input logic [3:0] idx,
                                         input logic [15:0][15:0] rf,
                                         input logic [19:0] w1,
                                         input logic [19:0] w2);
    if (idx == 4'd0)        return 16'd0;
    if (w2[19:16] == idx)   return w2[15:0];
    if (w1[19:16] == idx)   return w1[15:0];
    return rf[idx];
  endfunction

  logic [3:0]  dec_opc;
  logic [15:0] rs1_val, rs2_val, rd_val;
  logic        is_nop, is_imm, is_br, is_jmp;

  always_comb begin
    dec_opc = instr[15:12];
    rs1_val = rd_reg(instr[7:4],  rf_q, rdvalmem1, rdvalmem2);
    rs2_val = rd_reg(instr[3:0],  rf_q, rdvalmem1, rdvalmem2);
    rd_val  = rd_reg(instr[11:8], rf_q, rdvalmem1, rdvalmem2);
    is_nop  = (dec_opc == 4'h0);
    is_imm  = (dec_opc[3:2] == 2'b10);
    is_jmp  = (dec_opc == 4'hF);
    is_br   = (dec_opc[3:2] == 2'b11) && !is_jmp;
  end

  always_comb begin
    opcode_d        = opcode_q;
    op1_d           = op1_q;
    op2_d           = op2_q;
    imm_d           = imm_q;
    imm_flag_d      = imm_flag_q;
    branch_target_d = branch_target_q;
    instrout_d      = instrout_q;
    if (is_branch_taken) begin
      opcode_d        = 4'd0;
      op1_d           = 16'd0;
      op2_d           = 16'd0;
      imm_d           = 5'd0;
      imm_flag_d      = 1'b0;
      branch_target_d = 16'd0;
      instrout_d      = 16'd0;
    end else if (!stall) begin
      instrout_d      = instr;
      opcode_d        = dec_opc;
      op1_d           = is_nop ? 16'd0 : rs1_val;
      op2_d           = 16'd0;
      imm_d           = 5'd0;
      imm_flag_d      = 1'b0;
      branch_target_d = 16'd0;
      if (is_imm) begin
        op2_d      = {{11{instr[4]}}, instr[4:0]};
        imm_d      = instr[4:0];
        imm_flag_d = 1'b1;
      end else if (!is_nop) begin
        op2_d = rs2_val;
      end
      if (is_br)  branch_target_d = rd_val;
      if (is_jmp) branch_target_d = {4'b0, instr[11:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_q            <= '0;
      opcode_q        <= 4'd0;
      op1_q           <= 16'd0;
      op2_q           <= 16'd0;
      imm_q           <= 5'd0;
      imm_flag_q      <= 1'b0;
      branch_target_q <= 16'd0;
      instrout_q      <= 16'd0;
    end else begin
      rf_q            <= rf_d;
      opcode_q        <= opcode_d;
      op1_q           <= op1_d;
      op2_q           <= op2_d;
      imm_q           <= imm_d;
      imm_flag_q      <= imm_flag_d;
      branch_target_q <= branch_target_d;
      instrout_q      <= instrout_d;
    end
  end

  assign opcode        = opcode_q;
  assign op1           = op1_q;
  assign op2           = op2_q;
  assign imm           = imm_q;
  assign imm_flag      = imm_flag_q;
  assign branch_target = branch_target_q;
  assign instrout      = instrout_q;

endmodule

// File: tb/tb_decode_unit.sv
// Scoreboard bench for decode_unit: a reference register file and decoder
// predict each capture; directed cases also check fixed expected constants.
module tb_decode_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        is_branch_taken;
  logic [15:0] instr;
  logic [19:0] rdvalmem1, rdvalmem2;
  logic [3:0]  opcode;
  logic [15:0] op1, op2, branch_target, instrout;
  logic [4:0]  imm;
  logic        imm_flag;

  decode_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .is_branch_taken(is_branch_taken),
    .instr(instr), .rdvalmem1(rdvalmem1), .rdvalmem2(rdvalmem2),
    .opcode(opcode), .op1(op1), .op2(op2), .imm(imm), .imm_flag(imm_flag),
    .branch_target(branch_target), .instrout(instrout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  opc;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [4:0]  imm;
    logic        flag;
    logic [15:0] bt;
    logic [15:0] io;
  } out_t;

  int   vectors = 0;
  int   miscompares = 0;
  out_t exp_q[$];
  logic [15:0] mreg [16];
  out_t mout;
  out_t exp, got;

  function automatic out_t dut_out();
    return {opcode, op1, op2, imm, imm_flag, branch_target, instrout};
  endfunction

  function automatic out_t model_dec(input logic [15:0] i);
    out_t o;
    logic [3:0] c;
    o = '0;
    c = i[15:12];
    o.io  = i;
    o.opc = c;
    if (c == 4'h0) return o;
    o.op1 = mreg[i[7:4]];
    case (c)
      4'h8, 4'h9, 4'hA, 4'hB: begin
        o.op2  = {{11{i[4]}}, i[4:0]};
        o.imm  = i[4:0];
        o.flag = 1'b1;
      end
      default: o.op2 = mreg[i[3:0]];
    endcase
    if (c == 4'hC || c == 4'hD || c == 4'hE) o.bt = mreg[i[11:8]];
    if (c == 4'hF) o.bt = {4'h0, i[11:0]};
    return o;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 16; k++) mreg[k] = 16'h0;
    mout = '0;
  endtask

  // Drive one cycle, predict the capture, push it, and return just after the edge.
  task automatic step(input logic [15:0] i, input logic [19:0] w1, input logic [19:0] w2,
                      input logic s, input logic f);
    out_t e;
    @(negedge clk);
    instr = i; rdvalmem1 = w1; rdvalmem2 = w2; stall = s; is_branch_taken = f;
    if (w1[19:16] != 4'h0) mreg[w1[19:16]] = w1[15:0];
    if (w2[19:16] != 4'h0) mreg[w2[19:16]] = w2[15:0];
    if (f)      e = '0;
    else if (s) e = mout;
    else        e = model_dec(i);
    mout = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rdvalmem1 = 20'h0; rdvalmem2 = 20'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; is_branch_taken = 1'b0;
    instr = 16'h0; rdvalmem1 = 20'h0; rdvalmem2 = 20'h0;
    model_clear();
    #15;
    got = dut_out(); vectors++;
    if (got !== out_t'(0)) begin
      miscompares++; $display("FAIL reset_outputs: got %h expected %h", got, out_t'(0));
    end
    @(negedge clk);
    reset = 1'b0;
    step(16'h10F0, 20'h0, 20'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front(); got = dut_out(); vectors++;
    if (got !== exp) begin
      miscompares++; $display("FAIL reset_r15_read: got %h expected %h", got, exp);
    end
    vectors++;
    if (op1 !== 16'h0) begin
      miscompares++; $display("FAIL reset_r15_op1: got %h expected 0000", op1);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] ti [5] = '{16'h12F5, 16'h3AF5, 16'h4070, 16'h5770, 16'h6000};
    logic [19:0] t1 [5] = '{20'hF1234, 20'h0, 20'h7AAAA, 20'h0, 20'h0FFFF};
    logic [19:0] t2 [5] = '{20'h55678, 20'h0, 20'h7BBBB, 20'h0, 20'h0};
    for (int k = 0; k < 5; k++) begin
      step(ti[k], t1[k], t2[k], 1'b0, 1'b0);
      exp = exp_q.pop_front(); got = dut_out(); vectors++;
      if (got !== exp) begin
        miscompares++; $display("FAIL bypass_%0d: got %h expected %h", k, got, exp);
      end
      if (k == 0) begin
        vectors++;
        if ({opcode, op1, op2, imm_flag, instrout} !== {4'h1, 16'h1234, 16'h5678, 1'b0, 16'h12F5}) begin
          miscompares++;
          $display("FAIL bypass_const: got opc=%h op1=%h op2=%h flag=%b io=%h expected 1 1234 5678 0 12F5",
                   opcode, op1, op2, imm_flag, instrout);
        end
      end
      if (k == 2) begin
        vectors++;
        if (op1 !== 16'hBBBB) begin
          miscompares++; $display("FAIL same_index_priority: got %h expected BBBB", op1);
        end
      end
    end
  endtask

  task automatic test_immediate();
    logic [15:0] ti [4] = '{16'h0000, 16'h81F3, 16'h9A2C, 16'h0FFF};
    logic [19:0] t1 [4] = '{20'hF1234, 20'h0, 20'h2BEEF, 20'h3CAFE};
    for (int k = 0; k < 4; k++) begin
      step(ti[k], t1[k], 20'h0, 1'b0, 1'b0);
      exp = exp_q.pop_front(); got = dut_out(); vectors++;
      if (got !== exp) begin
        miscompares++; $display("FAIL immediate_%0d: got %h expected %h", k, got, exp);
      end
      if (k == 1) begin
        vectors++;
        if ({opcode, op1, imm, op2, imm_flag} !== {4'h8, 16'h1234, 5'h13, 16'hFFF3, 1'b1}) begin
          miscompares++;
          $display("FAIL immediate_const: got opc=%h op1=%h imm=%h op2=%h flag=%b expected 8 1234 13 FFF3 1",
                   opcode, op1, imm, op2, imm_flag);
        end
      end
      if (k == 3) begin
        vectors++;
        if (got !== out_t'({74'h0} | 16'h0FFF)) begin
          miscompares++; $display("FAIL nop_zero: got %h expected only instrout=0FFF", got);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] ti [3] = '{16'hF123, 16'h0000, 16'hC456};
    logic [19:0] t2 [3] = '{20'h3ABCD, 20'h400AA, 20'h0};
    logic [15:0] bt [3] = '{16'h0123, 16'h0000, 16'h00AA};
    for (int k = 0; k < 3; k++) begin
      step(ti[k], 20'h0, t2[k], 1'b0, 1'b0);
      exp = exp_q.pop_front(); got = dut_out(); vectors++;
      if (got !== exp) begin
        miscompares++; $display("FAIL branch_%0d: got %h expected %h", k, got, exp);
      end
      vectors++;
      if (branch_target !== bt[k]) begin
        miscompares++; $display("FAIL branch_target_%0d: got %h expected %h", k, branch_target, bt[k]);
      end
    end
  endtask

  task automatic test_stall();
    step(16'h1111, 20'h1DEAD, 20'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front(); got = dut_out(); vectors++;
    if (got !== exp) begin
      miscompares++; $display("FAIL stall_pre: got %h expected %h", got, exp);
    end
    for (int k = 0; k < 4; k++) begin
      step(16'h2345, (k < 3) ? {4'h4, 16'hA000 + 16'(k)} : 20'h0, 20'h0, (k < 3), 1'b0);
      exp = exp_q.pop_front(); got = dut_out(); vectors++;
      if (got !== exp) begin
        miscompares++; $display("FAIL stall_%0d: got %h expected %h", k, got, exp);
      end
      vectors++;
      if (instrout !== ((k < 3) ? 16'h1111 : 16'h2345)) begin
        miscompares++; $display("FAIL stall_instrout_%0d: got %h", k, instrout);
      end
    end
    vectors++;
    if (op1 !== 16'hA002) begin
      miscompares++; $display("FAIL stall_release_op1: got %h expected A002", op1);
    end
  endtask

  task automatic test_flush();
    step(16'h5123, 20'h31111, 20'h0, 1'b1, 1'b1);
    exp = exp_q.pop_front(); got = dut_out(); vectors++;
    if (got !== out_t'(0) || got !== exp) begin
      miscompares++; $display("FAIL flush_zero: got %h expected 0", got);
    end
    step(16'h1030, 20'h0, 20'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front(); got = dut_out(); vectors++;
    if (got !== exp || op1 !== 16'h1111) begin
      miscompares++; $display("FAIL flush_writeback: got %h expected %h (R3=1111)", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 40; k++) begin
      step(16'($urandom), 20'($urandom), 20'($urandom),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      exp = exp_q.pop_front(); got = dut_out(); vectors++;
      if (got !== exp) begin
        miscompares++; $display("FAIL b2b_%0d: got %h expected %h", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_midop();
    step(16'h7120, 20'hF4321, 20'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front(); got = dut_out(); vectors++;
    if (got !== exp) begin
      miscompares++; $display("FAIL midop_pre: got %h expected %h", got, exp);
    end
    @(negedge clk);
    stall = 1'b1; is_branch_taken = 1'b0;
    #2 reset = 1'b1;
    #1;
    got = dut_out(); vectors++;
    if (got !== out_t'(0)) begin
      miscompares++; $display("FAIL midop_async_clear: got %h expected 0", got);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0; stall = 1'b0;
    step(16'h10F0, 20'h0, 20'h0, 1'b0, 1'b0);
    exp = exp_q.pop_front(); got = dut_out(); vectors++;
    if (got !== exp || op1 !== 16'h0) begin
      miscompares++; $display("FAIL midop_rf_cleared: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bypass();
    test_immediate();
    test_branch();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
